// File: rtl/m_data_bus_pkg.sv
// Shared definitions for the data-side bus: I/O offsets, STATUS bit
// positions and the address-region type produced by the decoder.
package m_data_bus_pkg;

  localparam logic [31:0] DBUS_OFF_TXDATA = 32'h0000_0000;
  localparam logic [31:0] DBUS_OFF_STATUS = 32'h0000_0004;

  localparam int DBUS_ST_EMPTY = 0;
  localparam int DBUS_ST_FULL  = 1;
  localparam int DBUS_ST_OVF   = 2;

  typedef enum logic [1:0] {
    DBUS_RGN_RAM,
    DBUS_RGN_TXDATA,
    DBUS_RGN_STATUS,
    DBUS_RGN_NONE
  } dbus_region_e;

  // Byte-offset bits [1:0] are ignored for the I/O registers; the RAM bound
  // is a plain byte compare so any byte inside a word maps to that word.
  function automatic dbus_region_e dbus_decode(input logic [31:0] addr,
                                               input logic [31:0] ram_bytes,
                                               input logic [31:0] io_base);
    logic [31:0] tx_addr;
    logic [31:0] st_addr;
    tx_addr = io_base + DBUS_OFF_TXDATA;
    st_addr = io_base + DBUS_OFF_STATUS;
    if (addr < ram_bytes)
      return DBUS_RGN_RAM;
    else if (addr[31:2] == tx_addr[31:2])
      return DBUS_RGN_TXDATA;
    else if (addr[31:2] == st_addr[31:2])
      return DBUS_RGN_STATUS;
    else
      return DBUS_RGN_NONE;
  endfunction

endpackage

// File: rtl/m_data_bus_if.sv
// Core-side data port plus the TX stream. The core/consumer side uses the
// master modport, the bus itself uses the slave modport.
interface m_data_bus_if;
  import m_data_bus_pkg::*;

  logic        i_we;
  logic [31:0] i_address;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_tx_valid;
  logic [31:0] o_tx_data;
  logic        i_tx_ready;

  modport master (
    output i_we, i_address, i_wdata, i_tx_ready,
    input  o_rdata, o_tx_valid, o_tx_data
  );

  modport slave (
    input  i_we, i_address, i_wdata, i_tx_ready,
    output o_rdata, o_tx_valid, o_tx_data
  );
endinterface

// File: rtl/m_data_bus_tx_fifo.sv
// Transmit FIFO for the data bus. No fall-through: a word pushed into an
// empty FIFO becomes the head one cycle later. A push into a full FIFO is
// only accepted when a pop happens in the same cycle; otherwise the caller
// is expected to account for the drop.
module m_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  logic [31:0]            i_push_data,
  input  logic                   i_pop,
  output logic [31:0]            o_head,
  output logic                   o_valid,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop_ok;
  logic          push_ok;

  assign o_valid = (count != '0);
  assign o_full  = (count == FULL_COUNT);
  assign o_count = count;
  assign o_head  = mem[rd_ptr];
  assign pop_ok  = i_pop && o_valid;
  assign push_ok = i_push && (!o_full || pop_ok);

  // Pointer and occupancy bookkeeping; reset empties the FIFO immediately.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge i_clk) begin
    if (push_ok)
      mem[wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/m_data_bus.sv
// Data-side bus for the single-cycle core: decodes each access to the data
// RAM, the TX FIFO data port or the STATUS register; loads are combinational.
// Optional feature macro DBUS_OVERFLOW_EN adds the sticky overflow flag
// (STATUS[2], cleared by writing STATUS with bit 0 set).
module m_data_bus
  import m_data_bus_pkg::*;
#(
  parameter int          RAM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_0000
) (
  input logic           i_clk,
  input logic           i_reset,
  m_data_bus_if.slave   bus
);

  localparam int          RW        = $clog2(RAM_WORDS);
  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  dbus_region_e  region;
  logic [RW-1:0] ram_idx;
  logic [31:0]   ram [RAM_WORDS];
  logic          fifo_push;
  logic          fifo_valid;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic [31:0]   status_word;

  assign region    = dbus_decode(bus.i_address, RAM_BYTES, IO_BASE);
  assign ram_idx   = bus.i_address[RW+1:2];
  assign fifo_push = bus.i_we && (region == DBUS_RGN_TXDATA);

  m_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_push     (fifo_push),
    .i_push_data(bus.i_wdata),
    .i_pop      (bus.i_tx_ready),
    .o_head     (bus.o_tx_data),
    .o_valid    (fifo_valid),
    .o_full     (fifo_full),
    .o_count    (fifo_count)
  );

  assign bus.o_tx_valid = fifo_valid;

  // Data RAM write port; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (bus.i_we && (region == DBUS_RGN_RAM))
      ram[ram_idx] <= bus.i_wdata;
  end

`ifdef DBUS_OVERFLOW_EN
  logic push_rejected;
  assign push_rejected = fifo_push && fifo_full && !(fifo_valid && bus.i_tx_ready);

  // Sticky record of pushes dropped because the FIFO was full.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      overflow <= 1'b0;
    else if (push_rejected)
      overflow <= 1'b1;
    else if (bus.i_we && (region == DBUS_RGN_STATUS) && bus.i_wdata[0])
      overflow <= 1'b0;
  end
`else
  assign overflow = 1'b0;
`endif

  // Assemble the STATUS word from the FIFO flags and the overflow flag.
  always_comb begin
    status_word                = '0;
    status_word[DBUS_ST_EMPTY] = !fifo_valid;
    status_word[DBUS_ST_FULL]  = fifo_full;
    status_word[DBUS_ST_OVF]   = overflow;
  end

  // Combinational load mux so the core completes loads in one cycle.
  always_comb begin
    bus.o_rdata = '0;
    case (region)
      DBUS_RGN_RAM:    bus.o_rdata = ram[ram_idx];
      DBUS_RGN_TXDATA: bus.o_rdata = {{(32 - CW){1'b0}}, fifo_count};
      DBUS_RGN_STATUS: bus.o_rdata = status_word;
      default:         bus.o_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_m_data_bus.sv
// Directed, table-driven bench for m_data_bus: RAM round trip, unmapped
// accesses, TX fill/drain, overflow, full push+pop and mid-stream reset.
module tb_m_data_bus;

  localparam logic [31:0] TXA = 32'hFFFF_0000;
  localparam logic [31:0] STA = 32'hFFFF_0004;
`ifdef DBUS_OVERFLOW_EN
  localparam logic [31:0] ST_OVF_FULL = 32'd6;
`else
  localparam logic [31:0] ST_OVF_FULL = 32'd2;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
    logic        exp_valid;
    logic [31:0] exp_tx;
  } vec_t;

  logic i_clk = 1'b0;
  logic i_reset;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];

  m_data_bus_if bus_if ();

  m_data_bus dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus_if)
  );

  always #5 i_clk = ~i_clk;

  function automatic vec_t mk(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic ready,
                              input logic chk, input logic [31:0] exp_rdata,
                              input logic exp_valid, input logic [31:0] exp_tx);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.ready = ready;
    v.chk_rdata = chk; v.exp_rdata = exp_rdata;
    v.exp_valid = exp_valid; v.exp_tx = exp_tx;
    return v;
  endfunction

  // Drive one access between edges and let the combinational read settle.
  task automatic applyStimulus(input vec_t v);
    @(negedge i_clk);
    bus_if.i_we       = v.we;
    bus_if.i_address  = v.addr;
    bus_if.i_wdata    = v.wdata;
    bus_if.i_tx_ready = v.ready;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic checkVector(input string tag, input vec_t v);
    if (v.chk_rdata)
      checkOutput({tag, "_rdata"}, bus_if.o_rdata, v.exp_rdata);
    checkOutput({tag, "_valid"}, {31'b0, bus_if.o_tx_valid}, {31'b0, v.exp_valid});
    if (v.exp_valid)
      checkOutput({tag, "_txdata"}, bus_if.o_tx_data, v.exp_tx);
  endtask

  initial begin
    i_reset           = 1'b1;
    bus_if.i_we       = 1'b0;
    bus_if.i_address  = STA;
    bus_if.i_wdata    = '0;
    bus_if.i_tx_ready = 1'b0;

    // Expected values describe the state before the edge that commits the row.
    vecs.push_back(mk(0, STA,           0,            0, 1, 32'd1,        0, 0));
    vecs.push_back(mk(1, 32'h0,         32'hA5A5A5A5, 0, 0, 0,            0, 0));
    vecs.push_back(mk(1, 32'h10,        32'hDEADBEEF, 0, 0, 0,            0, 0));
    vecs.push_back(mk(0, 32'h10,        0,            0, 1, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(0, 32'h13,        0,            0, 1, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(1, 32'h8000_0000, 32'h12345678, 0, 1, 32'd0,        0, 0));
    vecs.push_back(mk(0, 32'h8000_0000, 0,            0, 1, 32'd0,        0, 0));
    vecs.push_back(mk(1, 32'h400,       32'hCAFEF00D, 0, 1, 32'd0,        0, 0));
    vecs.push_back(mk(0, 32'h0,         0,            0, 1, 32'hA5A5A5A5, 0, 0));
    vecs.push_back(mk(0, STA,           0,            0, 1, 32'd1,        0, 0));
    vecs.push_back(mk(1, TXA,           32'd1,        0, 1, 32'd0,        0, 0));
    vecs.push_back(mk(1, TXA,           32'd2,        0, 1, 32'd1,        1, 32'd1));
    vecs.push_back(mk(1, TXA,           32'd3,        0, 1, 32'd2,        1, 32'd1));
    vecs.push_back(mk(1, TXA,           32'd4,        0, 1, 32'd3,        1, 32'd1));
    vecs.push_back(mk(0, STA,           0,            0, 1, 32'd2,        1, 32'd1));
    vecs.push_back(mk(0, TXA,           0,            0, 1, 32'd4,        1, 32'd1));
    vecs.push_back(mk(1, TXA,           32'd5,        0, 1, 32'd4,        1, 32'd1));
    vecs.push_back(mk(0, STA,           0,            0, 1, ST_OVF_FULL,  1, 32'd1));
    vecs.push_back(mk(1, STA,           32'd1,        0, 1, ST_OVF_FULL,  1, 32'd1));
    vecs.push_back(mk(0, STA,           0,            0, 1, 32'd2,        1, 32'd1));
    vecs.push_back(mk(0, STA,           0,            1, 1, 32'd2,        1, 32'd1));
    vecs.push_back(mk(0, TXA,           0,            1, 1, 32'd3,        1, 32'd2));
    vecs.push_back(mk(0, TXA,           0,            1, 1, 32'd2,        1, 32'd3));
    vecs.push_back(mk(0, TXA,           0,            1, 1, 32'd1,        1, 32'd4));
    vecs.push_back(mk(0, STA,           0,            0, 1, 32'd1,        0, 0));
    vecs.push_back(mk(1, TXA,           32'd10,       0, 1, 32'd0,        0, 0));
    vecs.push_back(mk(1, TXA,           32'd11,       0, 1, 32'd1,        1, 32'd10));
    vecs.push_back(mk(1, TXA,           32'd12,       0, 1, 32'd2,        1, 32'd10));
    vecs.push_back(mk(1, TXA,           32'd13,       0, 1, 32'd3,        1, 32'd10));
    vecs.push_back(mk(1, TXA,           32'd9,        1, 1, 32'd4,        1, 32'd10));
    vecs.push_back(mk(0, STA,           0,            0, 1, 32'd2,        1, 32'd11));
    vecs.push_back(mk(0, TXA,           0,            1, 1, 32'd4,        1, 32'd11));
    vecs.push_back(mk(0, TXA,           0,            1, 1, 32'd3,        1, 32'd12));
    vecs.push_back(mk(0, TXA,           0,            1, 1, 32'd2,        1, 32'd13));
    vecs.push_back(mk(0, TXA,           0,            1, 1, 32'd1,        1, 32'd9));
    vecs.push_back(mk(0, STA,           0,            0, 1, 32'd1,        0, 0));
    vecs.push_back(mk(1, TXA,           32'd7,        1, 1, 32'd0,        0, 0));
    vecs.push_back(mk(0, TXA,           0,            0, 1, 32'd1,        1, 32'd7));
    vecs.push_back(mk(1, TXA,           32'd8,        0, 1, 32'd1,        1, 32'd7));

    #2;
    checkOutput("reset_valid", {31'b0, bus_if.o_tx_valid}, 32'd0);
    checkOutput("reset_status", bus_if.o_rdata, 32'd1);
    @(negedge i_clk);
    i_reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkVector($sformatf("vec%0d", i), vecs[i]);
    end

    // Two entries queued (7, 8); reset lands between clock edges.
    applyStimulus(mk(0, STA, 0, 0, 1, 32'd0, 1, 32'd7));
    checkVector("pre_reset", mk(0, STA, 0, 0, 1, 32'd0, 1, 32'd7));
    #2;
    i_reset = 1'b1;
    #1;
    checkOutput("async_reset_valid", {31'b0, bus_if.o_tx_valid}, 32'd0);
    checkOutput("async_reset_status", bus_if.o_rdata, 32'd1);
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    checkOutput("post_reset_status", bus_if.o_rdata, 32'd1);
    checkOutput("post_reset_valid", {31'b0, bus_if.o_tx_valid}, 32'd0);
    applyStimulus(mk(0, 32'h10, 0, 0, 1, 32'hDEADBEEF, 0, 0));
    checkVector("post_reset_ram10", mk(0, 32'h10, 0, 0, 1, 32'hDEADBEEF, 0, 0));
    applyStimulus(mk(0, 32'h0, 0, 0, 1, 32'hA5A5A5A5, 0, 0));
    checkVector("post_reset_ram0", mk(0, 32'h0, 0, 0, 1, 32'hA5A5A5A5, 0, 0));
    applyStimulus(mk(1, TXA, 32'h55, 0, 1, 32'd0, 0, 0));
    checkVector("post_reset_push", mk(1, TXA, 32'h55, 0, 1, 32'd0, 0, 0));
    applyStimulus(mk(0, TXA, 0, 0, 1, 32'd1, 1, 32'h55));
    checkVector("post_reset_head", mk(0, TXA, 0, 0, 1, 32'd1, 1, 32'h55));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
